// File: rtl/gauss_pkg.sv
// gauss_pkg: fill-mode and state encodings plus default window geometry
// shared by the window buffer and the Gaussian convolution stage.
package gauss_pkg;
    typedef enum logic [1:0] {
        MODE_ADDR   = 2'b00,
        MODE_RASTER = 2'b01,
        MODE_SHIFT  = 2'b10
    } mode_t;
    typedef enum logic {
        FILLING = 1'b0,
        HOLD    = 1'b1
    } state_t;
    localparam int DEF_WIN   = 6;
    localparam int DEF_PIX_W = 8;
endpackage

// File: rtl/gauss_wrap_counter.sv
// gauss_wrap_counter: x/y position counter with wrap and last-cell flag;
// with use_x low it counts rows only.
module gauss_wrap_counter #(
    parameter int N = 6,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         use_x,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         last
);
    localparam logic [W-1:0] MAX = W'(N - 1);
    logic x_wrap;
    assign x_wrap = !use_x || x == MAX;
    assign last   = x_wrap && y == MAX;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            x <= x_wrap ? '0 : x + 1'b1;
            y <= last ? '0 : x_wrap ? y + 1'b1 : y;
        end
endmodule

// File: rtl/gauss_window_buffer.sv
// gauss_window_buffer: WIN x WIN pixel window with addressed, raster and sliding-column fill.
// Optional sticky coord_err output when GAUSS_WIN_COORD_ERR_EN is defined.
module gauss_window_buffer
    import gauss_pkg::*;
#(
    parameter int WIN     = DEF_WIN,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int COORD_W = 4,
    localparam int CNT_W  = $clog2(WIN * WIN + 1)
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             clear,
    input  logic [1:0]                       mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [COORD_W-1:0]               x_in,
    input  logic [COORD_W-1:0]               y_in,
    input  logic [PIX_W-1:0]                 pixel_in,
    input  logic                             win_ack,
    output logic                             full,
    output logic [CNT_W-1:0]                 fill_count,
    output logic [WIN-1:0][WIN-1:0][PIX_W-1:0] buffer_out
`ifdef GAUSS_WIN_COORD_ERR_EN
    ,
    output logic                             coord_err
`endif
);
    localparam int IDX_W = $clog2(WIN);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIN * WIN);
    localparam logic [CNT_W-1:0] COL_CNT  = CNT_W'(WIN);
    state_t                    state;
    mode_t                     active_mode, mode_sel, eff_mode;
    logic [WIN-1:0][WIN-1:0]   written;
    logic [WIN-1:0][PIX_W-1:0] stage, column;
    logic [IDX_W-1:0]          cx, cy, ax, ay;
    logic                      cnt_last, latch_open, accept, release_win, in_range;
    logic [CNT_W-1:0]          addr_count, shift_count;
    assign in_ready    = state == FILLING;
    assign full        = state == HOLD;
    // mode may only change while the window is empty and no column is half-staged
    assign latch_open  = in_ready && fill_count == '0 && !(active_mode == MODE_SHIFT && cy != '0);
    assign mode_sel    = mode == 2'b11 ? MODE_ADDR : mode_t'(mode);
    assign eff_mode    = latch_open ? mode_sel : active_mode;
    assign accept      = in_valid && in_ready && !clear;
    assign release_win = full && win_ack;
    assign ax          = x_in[IDX_W-1:0];
    assign ay          = y_in[IDX_W-1:0];
    assign in_range    = x_in < COORD_W'(WIN) && y_in < COORD_W'(WIN);
    assign addr_count  = fill_count + CNT_W'(!written[ax][ay]);
    assign shift_count = fill_count > FULL_CNT - COL_CNT ? FULL_CNT : fill_count + COL_CNT;
    always_comb begin
        column          = stage;
        column[WIN-1]   = pixel_in;
    end
    gauss_wrap_counter #(.N(WIN), .W(IDX_W)) u_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clear || release_win),
        .inc   (accept && eff_mode != MODE_ADDR),
        .use_x (eff_mode == MODE_RASTER),
        .x     (cx),
        .y     (cy),
        .last  (cnt_last)
    );
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state       <= FILLING;
            active_mode <= MODE_ADDR;
            buffer_out  <= '0;
            written     <= '0;
            stage       <= '0;
            fill_count  <= '0;
        end else begin
            if (latch_open) active_mode <= mode_sel;
            if (clear) begin
                state      <= FILLING;
                buffer_out <= '0;
                written    <= '0;
                stage      <= '0;
                fill_count <= '0;
            end else if (release_win) begin
                state   <= FILLING;
                written <= '0;
                if (active_mode != MODE_SHIFT) fill_count <= '0;
            end else if (accept) begin
                if (eff_mode == MODE_RASTER) begin
                    buffer_out[cx][cy] <= pixel_in;
                    fill_count         <= fill_count + 1'b1;
                    if (cnt_last) state <= HOLD;
                end else if (eff_mode == MODE_SHIFT) begin
                    stage[cy] <= pixel_in;
                    if (cnt_last) begin
                        buffer_out <= {column, buffer_out[WIN-1:1]};
                        fill_count <= shift_count;
                        if (shift_count == FULL_CNT) state <= HOLD;
                    end
                end else if (in_range) begin
                    buffer_out[ax][ay] <= pixel_in;
                    written[ax][ay]    <= 1'b1;
                    fill_count         <= addr_count;
                    if (addr_count == FULL_CNT) state <= HOLD;
                end
            end
        end
`ifdef GAUSS_WIN_COORD_ERR_EN
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) coord_err <= 1'b0;
        else if (clear) coord_err <= 1'b0;
        else if (accept && eff_mode == MODE_ADDR && !in_range) coord_err <= 1'b1;
`endif
endmodule

// File: doc/gauss_window_buffer.md
Name: gauss_window_buffer

Overview:
Parametrised successor to the fixed 6x6 Gaussian pixel buffer. Holds a WIN x WIN window of PIX_W-bit pixels that feeds the Gaussian convolution stage. Three fill modes: addressed write, raster auto-fill and sliding-column shift. A valid/ready input handshake and a window-complete hold/ack handshake keep the window stable while the downstream stage consumes it.

Parameters:
WIN, 6, window edge length in pixels (2..15)
PIX_W, 8, pixel width in bits
COORD_W, 4, width of x_in/y_in; must satisfy 2**COORD_W > WIN
CNT_W, $clog2(WIN*WIN+1), width of fill_count (derived localparam)

Ports:
clk  in  1  system clock
n_rst  in  1  reset; asynchronous, active-low
clear  in  1  synchronous clear of window, counters and state
mode  in  2  fill mode: 00 ADDR, 01 RASTER, 10 SHIFT, 11 reserved (treated as ADDR)
in_valid  in  1  pixel_in/x_in/y_in valid
in_ready  out  1  block accepts a pixel; transfer occurs when in_valid && in_ready
x_in  in  COORD_W  column coordinate; used in ADDR mode only
y_in  in  COORD_W  row coordinate; used in ADDR mode only
pixel_in  in  PIX_W  pixel data
win_ack  in  1  downstream has consumed the window
full  out  1  window complete and held
fill_count  out  CNT_W  number of distinct cells written since the last release
buffer_out  out  [WIN-1:0][WIN-1:0][PIX_W-1:0]  window, indexed buffer_out[x][y]

Behaviour:
- Reset (n_rst=0, asynchronous): all buffer_out cells = 0; full = 0; fill_count = 0; in_ready = 1; state = FILLING; active mode = ADDR; internal counters = 0.
- Mode latch: mode is sampled into active_mode on every edge while state = FILLING and fill_count = 0 and no staging data is pending. Mode changes at any other time are ignored.
- States: FILLING and HOLD.
  - in_ready = (state == FILLING); full = (state == HOLD).
  - FILLING -> HOLD on the edge that completes the window.
  - HOLD -> FILLING on the edge where win_ack = 1. On that edge fill_count, the written bitmap and the raster counter are cleared. Window contents are retained.
  - win_ack in FILLING is ignored.
- ADDR mode:
  - An accepted pixel is written to cell [x_in][y_in].
  - If x_in >= WIN or y_in >= WIN, the pixel is accepted but dropped.
  - A per-cell written bitmap tracks coverage; fill_count increments only when the target cell was previously unwritten.
  - The window completes when fill_count reaches WIN*WIN.
- RASTER mode:
  - Internal counters (rx, ry) start at (0,0). x increments fastest; x wraps from WIN-1 to 0 and increments y.
  - x_in and y_in are ignored.
  - The window completes when cell (WIN-1, WIN-1) is accepted. The counters then wrap to (0,0).
- SHIFT mode:
  - Accepted pixels fill a WIN-entry staging column at row r (0..WIN-1).
  - On the edge that accepts row WIN-1, the window commits in one cycle: buffer_out[x] <= buffer_out[x+1] for x < WIN-1, and buffer_out[WIN-1] <= the staging column.
  - fill_count adds WIN per commit, saturating at WIN*WIN.
  - The window completes on any commit after which fill_count = WIN*WIN. After the first full window, every further column commit re-enters HOLD.
  - On win_ack in SHIFT mode, fill_count stays at WIN*WIN and is not cleared.
- Latency: a write is visible on buffer_out one cycle after the accepting edge. full rises on the same edge that accepts or commits the final pixel.
- clear (synchronous): priority is below reset and above all other inputs.
  - Effect: zeroes all cells, staging column, counters, bitmap and fill_count; state = FILLING.
  - A pixel presented in the same cycle as clear is dropped. win_ack in the same cycle as clear is ignored.
- Reset mid-fill or in HOLD: the block returns immediately to the reset state.

Optional Feature:
GAUSS_WIN_COORD_ERR_EN
- Defined: adds output coord_err (1 bit). coord_err is sticky, sets on any accepted ADDR pixel with an out-of-range coordinate, and is cleared by n_rst or clear.
- Undefined: the port is absent and out-of-range pixels are dropped silently.

Decomposition:
- Package gauss_pkg holds: the fill-mode enum (MODE_ADDR, MODE_RASTER, MODE_SHIFT), the state enum (FILLING, HOLD), and default WIN/PIX_W constants shared with the convolution stage.
- One sub-module, gauss_wrap_counter: parametrised x/y counter with wrap and last-cell flag. It serves as the raster counter in RASTER mode and as the row counter (y only) in SHIFT mode.

Test Plan:
All scenarios use WIN=6, PIX_W=8.
1. Reset, then idle 2 cycles -> all buffer_out = 0x00, full = 0, in_ready = 1, fill_count = 0.
2. ADDR: write (3,5) = 0x0F -> buffer_out[3][5] = 0x0F next cycle, fill_count = 1. Rewrite (3,5) = 0x10 -> value 0x10, fill_count still 1.
3. RASTER: 36 pixels with values 1..36 -> buffer_out[x][y] = 1+x+6y, full = 1, in_ready = 0. A 37th in_valid is not accepted. win_ack -> full = 0, fill_count = 0, contents unchanged.
4. SHIFT: 7 columns with column k, row r = 16k+r (k = 0..6).
   - After column 5: full = 1.
   - win_ack, then column 6 -> full = 1 again, buffer_out[0][r] = 16+r, buffer_out[5][r] = 96+r.
5. ADDR: x_in = 7, y_in = 0, pixel = 0xAA -> no cell changes, fill_count unchanged. With the macro defined, coord_err = 1 until clear.
6. clear and in_valid in the same cycle, mid-RASTER with 10 pixels loaded -> all cells = 0, fill_count = 0, pixel dropped. Repeat with n_rst pulsed in HOLD -> reset state.
